// File: rtl/match_timer.sv
// match_timer: prescaled up-counter with periodic/one-shot terminal count
// and NCH compare channels, each raising a one-cycle match pulse the cycle
// the counter first shows that channel's compare value.
module match_timer #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int PRESC_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 MODE,
    input  logic [PRESC_W-1:0]   PRESC,
    input  logic [WIDTH-1:0]     PERIOD,
    input  logic [NCH*WIDTH-1:0] MATCH_IN,
    output logic [WIDTH-1:0]     CNT_OUT,
    output logic [NCH-1:0]       MATCH_OUT,
    output logic                 PERIOD_OUT,
    output logic                 BUSY
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [PRESC_W-1:0] presc_cnt, presc_nxt;
    logic [NCH-1:0]     match, match_nxt;
    logic [NCH-1:0]     eq_zero, eq_inc;
    logic               per, per_nxt;
    logic               tick, terminal;

    assign cnt_inc  = cnt + WIDTH'(1);
    assign terminal = (cnt >= PERIOD);
    assign tick     = (state == RUN) && EN && (presc_cnt == PRESC);

    // Per-channel compares against the two possible next-count values.
    always_comb begin
        eq_zero = '0;
        eq_inc  = '0;
        for (int i = 0; i < NCH; i++) begin
            eq_zero[i] = (MATCH_IN[i*WIDTH +: WIDTH] == '0);
            eq_inc[i]  = (MATCH_IN[i*WIDTH +: WIDTH] == cnt_inc);
        end
    end

    // Next-state and next-output logic; pulses default low so every
    // non-tick cycle clears them.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        presc_nxt = presc_cnt;
        match_nxt = '0;
        per_nxt   = 1'b0;
        if (STOP) begin
            // STOP beats a coincident START; count is held.
            state_nxt = IDLE;
        end else if (START) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            presc_nxt = '0;
            match_nxt = eq_zero;
        end else if (state == RUN && EN) begin
            presc_nxt = tick ? '0 : presc_cnt + PRESC_W'(1);
            if (tick) begin
                if (terminal) begin
                    // >= also catches a PERIOD lowered below the count.
                    per_nxt = 1'b1;
                    cnt_nxt = '0;
                    if (MODE) begin
                        state_nxt = IDLE;
                    end else begin
                        match_nxt = eq_zero;
                    end
                end else begin
                    cnt_nxt   = cnt_inc;
                    match_nxt = eq_inc;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            presc_cnt <= '0;
            match     <= '0;
            per       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            presc_cnt <= presc_nxt;
            match     <= match_nxt;
            per       <= per_nxt;
        end
    end

    assign CNT_OUT    = cnt;
    assign MATCH_OUT  = match;
    assign PERIOD_OUT = per;
    assign BUSY       = (state == RUN);

endmodule

// File: tb/tb_match_timer.sv
// Directed bench for match_timer (WIDTH=5, NCH=2, PRESC_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_match_timer;

    localparam int W  = 5;
    localparam int N  = 2;
    localparam int PW = 4;

    logic           CLK = 1'b0;
    logic           RST, EN, START, STOP, MODE;
    logic [PW-1:0]  PRESC;
    logic [W-1:0]   PERIOD, m0, m1;
    logic [N*W-1:0] MATCH_IN;
    logic [W-1:0]   CNT_OUT;
    logic [N-1:0]   MATCH_OUT;
    logic           PERIOD_OUT, BUSY;

    int tests = 0;
    int fails = 0;

    assign MATCH_IN = {m1, m0};

    always #5 CLK = ~CLK;

    match_timer #(.WIDTH(W), .NCH(N), .PRESC_W(PW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .STOP(STOP),
        .MODE(MODE), .PRESC(PRESC), .PERIOD(PERIOD), .MATCH_IN(MATCH_IN),
        .CNT_OUT(CNT_OUT), .MATCH_OUT(MATCH_OUT), .PERIOD_OUT(PERIOD_OUT),
        .BUSY(BUSY)
    );

    // m: bit0 = channel 0, bit1 = channel 1
    task automatic expect_all(input string tag, input int c, input int m,
                              input bit p, input bit b);
        logic [8:0] got, want;
        got  = {CNT_OUT, MATCH_OUT, PERIOD_OUT, BUSY};
        want = {c[4:0], m[1:0], p, b};
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed cnt=%0d match=%b per=%b busy=%b, expected cnt=%0d match=%b per=%b busy=%b",
                   tag, got[8:4], got[3:2], got[1], got[0],
                   want[8:4], want[3:2], want[1], want[0]);
        end
    endtask

    initial begin
        // Reset with START held high
        RST = 1'b0; START = 1'b1; STOP = 1'b0; EN = 1'b1; MODE = 1'b0;
        PRESC = 0; PERIOD = 20; m0 = 20; m1 = 5;
        repeat (3) @(negedge CLK);
        expect_all("reset", 0, 0, 0, 0);
        RST = 1'b1; START = 1'b0;
        @(negedge CLK);
        expect_all("idle", 0, 0, 0, 0);

        // Periodic basic: PERIOD=20, MATCH0=20, MATCH1=5
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("start", 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            int m;
            m = 0;
            if (k == 20) m = m | 1;
            if (k == 5)  m = m | 2;
            @(negedge CLK);
            expect_all("periodic", k, m, 1'b0, 1'b1);
        end
        @(negedge CLK);
        expect_all("wrap", 0, 0, 1, 1);
        repeat (19) @(negedge CLK);
        expect_all("cnt19_2", 19, 0, 0, 1);
        @(negedge CLK);
        expect_all("match0_2", 20, 1, 0, 1);
        @(negedge CLK);
        expect_all("wrap2", 0, 0, 1, 1);

        // Prescale: PRESC=3, PERIOD=4, MATCH0=2, MATCH1 above PERIOD
        PRESC = 3; PERIOD = 4; m0 = 2; m1 = 31; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("presc_start", 0, 0, 0, 1);
        for (int e = 1; e <= 40; e++) begin
            @(negedge CLK);
            expect_all("prescale", (e / 4) % 5, (e % 20 == 8) ? 1 : 0,
                       (e % 20 == 0), 1'b1);
        end

        // PERIOD=0 periodic: count pinned at 0, terminal every tick
        PRESC = 0; PERIOD = 0; m0 = 0; m1 = 1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("p0_start", 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            expect_all("p0_tick", 0, 1, 1, 1);
        end

        // One-shot: PERIOD=7, MATCH0=0, MATCH1=3
        MODE = 1'b1; PERIOD = 7; m0 = 0; m1 = 3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("os_start", 0, 1, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            expect_all("oneshot", k, (k == 3) ? 2 : 0, 1'b0, 1'b1);
        end
        @(negedge CLK);
        expect_all("os_term", 0, 0, 1, 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            expect_all("os_idle", 0, 0, 0, 0);
        end

        // Control: EN low, restart, START+STOP
        MODE = 1'b0; PERIOD = 30; m0 = 25; m1 = 9; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("ctl_start", 0, 0, 0, 1);
        repeat (9) @(negedge CLK);
        expect_all("ctl_c9", 9, 2, 0, 1);
        EN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            expect_all("en_low", 9, 0, 0, 1);
        end
        EN = 1'b1;
        @(negedge CLK);
        expect_all("resume", 10, 0, 0, 1);
        repeat (2) @(negedge CLK);
        expect_all("ctl_c12", 12, 0, 0, 1);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("restart", 0, 0, 0, 1);
        repeat (3) @(negedge CLK);
        expect_all("ctl_c3", 3, 0, 0, 1);
        START = 1'b1; STOP = 1'b1;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        expect_all("start_stop", 3, 0, 0, 0);
        repeat (2) @(negedge CLK);
        expect_all("stopped", 3, 0, 0, 0);

        // Runtime PERIOD shrink 30 -> 10 at CNT=15, then mid-run reset
        PERIOD = 30; m0 = 0; m1 = 15; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        expect_all("sh_start", 0, 1, 0, 1);
        repeat (15) @(negedge CLK);
        expect_all("sh_c15", 15, 2, 0, 1);
        PERIOD = 10;
        @(negedge CLK);
        expect_all("shrink", 0, 1, 1, 1);
        @(negedge CLK);
        expect_all("sh_after", 1, 0, 0, 1);
        @(negedge CLK);
        RST = 1'b0; START = 1'b1;
        @(negedge CLK);
        expect_all("mid_reset", 0, 0, 0, 0);
        RST = 1'b1; START = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
